// File: rtl/pkt_classifier.sv
// Ingress packet classifier: buffers AXI-Stream beats in a fallthrough FIFO and steers each
// packet to the data path, the control path (UDP to a runtime port) or drops it.
module pkt_classifier #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int FIFO_DEPTH_BITS      = 5,
    parameter int NON_UDP_MODE         = 0,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
    output logic                              ctrl_m_axis_tvalid,
    output logic                              ctrl_m_axis_tlast,
    input  logic                              ctrl_m_axis_tready,

    input  logic [15:0]                       ctrl_udp_port,
    input  logic                              cnt_clr,
    output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              drop_pkt_cnt
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int WW    = DW + KW + UW + 1;
    localparam int PW    = FIFO_DEPTH_BITS;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [PW:0] NF_LEVEL = (PW + 1)'(DEPTH - 1);
    localparam bit FWD_NON_UDP = (NON_UDP_MODE != 0);

    typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_FWD_DATA, ST_FWD_CTRL, ST_DROP} state_t;

    state_t           state, state_nxt;
    logic [WW-1:0]    fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      fifo_cnt, fifo_cnt_nxt;
    logic             fifo_nearly_full, fifo_empty, wr_en, pop;
    logic [WW-1:0]    head;
    logic [DW-1:0]    head_data, hold_data;
    logic [KW-1:0]    head_keep, hold_keep;
    logic [UW-1:0]    head_user, hold_user;
    logic             head_last, is_ipv4_udp, port_match;
    logic             data_free, ctrl_free;
    logic             hold_load, use_hold, load_data, load_ctrl, drop_inc;

    assign wr_en         = s_axis_tvalid & s_axis_tready;
    assign s_axis_tready = ~fifo_nearly_full;
    assign fifo_empty    = (fifo_cnt == '0);
    assign fifo_cnt_nxt  = fifo_cnt + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, pop};

    // NOTE: the FIFO storage has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    end

    // nearly_full resets high so tready rises only on the first edge after reset release.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            fifo_cnt         <= '0;
            fifo_nearly_full <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt         <= fifo_cnt_nxt;
            fifo_nearly_full <= (fifo_cnt_nxt >= NF_LEVEL);
        end
    end

    assign head        = fifo_mem[rd_ptr];
    assign head_data   = head[DW-1:0];
    assign head_keep   = head[DW +: KW];
    assign head_user   = head[DW+KW +: UW];
    assign head_last   = head[WW-1];
    assign is_ipv4_udp = (head_data[143:128] == 16'h0008) && (head_data[223:216] == 8'h11);
    assign port_match  = (head_data[79:64] == ctrl_udp_port);
    assign data_free   = ~m_axis_tvalid | m_axis_tready;
    assign ctrl_free   = ~ctrl_m_axis_tvalid | ctrl_m_axis_tready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        hold_load = 1'b0;
        use_hold  = 1'b0;
        load_data = 1'b0;
        load_ctrl = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            ST_IDLE: if (!fifo_empty) begin
                if (is_ipv4_udp) begin
                    pop = 1'b1;
                    if (head_last) drop_inc = 1'b1;
                    else begin
                        hold_load = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (!FWD_NON_UDP) begin
                    pop = 1'b1;
                    if (head_last) drop_inc = 1'b1;
                    else           state_nxt = ST_DROP;
                end else if (data_free) begin
                    pop       = 1'b1;
                    load_data = 1'b1;
                    if (!head_last) state_nxt = ST_FWD_DATA;
                end
            end
            // The head now holds beat2; beat1 leaves from the hold register without a pop.
            ST_HOLD: if (!fifo_empty) begin
                use_hold = 1'b1;
                if (port_match) begin
                    if (ctrl_free) begin
                        load_ctrl = 1'b1;
                        state_nxt = ST_FWD_CTRL;
                    end
                end else if (data_free) begin
                    load_data = 1'b1;
                    state_nxt = ST_FWD_DATA;
                end
            end
            ST_FWD_DATA: if (!fifo_empty && data_free) begin
                pop       = 1'b1;
                load_data = 1'b1;
                if (head_last) state_nxt = ST_IDLE;
            end
            ST_FWD_CTRL: if (!fifo_empty && ctrl_free) begin
                pop       = 1'b1;
                load_ctrl = 1'b1;
                if (head_last) state_nxt = ST_IDLE;
            end
            ST_DROP: if (!fifo_empty) begin
                pop = 1'b1;
                if (head_last) begin
                    drop_inc  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            hold_data <= '0;
            hold_keep <= '0;
            hold_user <= '0;
        end else begin
            state <= state_nxt;
            if (hold_load) begin
                hold_data <= head_data;
                hold_keep <= head_keep;
                hold_user <= head_user;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_data) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= use_hold ? hold_data : head_data;
            m_axis_tkeep  <= use_hold ? hold_keep : head_keep;
            m_axis_tuser  <= use_hold ? hold_user : head_user;
            m_axis_tlast  <= use_hold ? 1'b0 : head_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_m_axis_tvalid <= 1'b0;
            ctrl_m_axis_tdata  <= '0;
            ctrl_m_axis_tkeep  <= '0;
            ctrl_m_axis_tuser  <= '0;
            ctrl_m_axis_tlast  <= 1'b0;
        end else if (load_ctrl) begin
            ctrl_m_axis_tvalid <= 1'b1;
            ctrl_m_axis_tdata  <= use_hold ? hold_data : head_data;
            ctrl_m_axis_tkeep  <= use_hold ? hold_keep : head_keep;
            ctrl_m_axis_tuser  <= use_hold ? hold_user : head_user;
            ctrl_m_axis_tlast  <= use_hold ? 1'b0 : head_last;
        end else if (ctrl_m_axis_tready) begin
            ctrl_m_axis_tvalid <= 1'b0;
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc);
        if (inc && !(&c)) return c + CNT_WIDTH'(1);
        return c;
    endfunction

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            data_pkt_cnt <= '0;
            ctrl_pkt_cnt <= '0;
            drop_pkt_cnt <= '0;
        end else if (cnt_clr) begin
            data_pkt_cnt <= '0;
            ctrl_pkt_cnt <= '0;
            drop_pkt_cnt <= '0;
        end else begin
            data_pkt_cnt <= sat_inc(data_pkt_cnt, m_axis_tvalid & m_axis_tready & m_axis_tlast);
            ctrl_pkt_cnt <= sat_inc(ctrl_pkt_cnt, ctrl_m_axis_tvalid & ctrl_m_axis_tready & ctrl_m_axis_tlast);
            drop_pkt_cnt <= sat_inc(drop_pkt_cnt, drop_inc);
        end
    end

endmodule
